// File: rtl/pcm_mm_pkg.sv
// Shared types and helpers for the pcm_mem_mm responder: bus widths, FSM state, byte merge.
package pcm_mm_pkg;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;
  localparam int BE_W   = 2;

  typedef enum logic {CLEAR, READY} state_t;

  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] m;
    m = old_w;
    for (int b = 0; b < BE_W; b++)
      if (be[b]) m[b*8 +: 8] = new_w[b*8 +: 8];
    return m;
  endfunction

  // One even-parity bit per byte, bit0 covers [7:0].
  function automatic logic [BE_W-1:0] byte_parity(input logic [DATA_W-1:0] w);
    return {^w[15:8], ^w[7:0]};
  endfunction
endpackage

// File: rtl/pcm_mem_mm_rd_pipe.sv
// clken-gated read-return pipeline of {valid, data}; each stage keeps the last valid
// data it saw so readdata holds between responses. Flush clears valid and data.
module pcm_mem_mm_rd_pipe #(
  parameter int LAT = 1,
  parameter int W   = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clken,
  input  logic         flush,
  input  logic         in_vld,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  output logic [W-1:0] out_data
);
  logic [LAT-1:0]        vld_pipe_q, vld_pipe_d;
  logic [LAT-1:0][W-1:0] dat_q, dat_d;
  logic [LAT:0]          v_chain;
  logic [LAT:0][W-1:0]   d_chain;

  always_comb begin
    v_chain    = {vld_pipe_q, in_vld};
    d_chain    = {dat_q, in_data};
    vld_pipe_d = vld_pipe_q;
    dat_d      = dat_q;
    if (flush) begin
      vld_pipe_d = '0;
      dat_d      = '0;
    end else if (clken) begin
      for (int i = 0; i < LAT; i++) begin
        vld_pipe_d[i] = v_chain[i];
        if (v_chain[i]) dat_d[i] = d_chain[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe_q <= '0;
      dat_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      dat_q      <= dat_d;
    end
  end

  assign out_vld  = vld_pipe_q[LAT-1];
  assign out_data = dat_q[LAT-1];
endmodule

// File: rtl/pcm_mem_mm_responder.sv
// PCM word store with byte-enabled writes, fixed-latency reads and a clear sequencer.
// Define PCM_MEM_MM_PARITY_EN to store per-byte parity and report read parity errors.
module pcm_mem_mm_responder
  import pcm_mm_pkg::*;
#(
  parameter int          DEPTH        = 2048,
  parameter int          READ_LATENCY = 1,
  parameter logic [15:0] INIT_VALUE   = 16'h0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [ADDR_W-1:0] pcm_mem_mm_address,
  input  logic              pcm_mem_mm_chipselect,
  input  logic              pcm_mem_mm_clken,
  input  logic              pcm_mem_mm_write,
  input  logic [DATA_W-1:0] pcm_mem_mm_writedata,
  input  logic [BE_W-1:0]   pcm_mem_mm_byteenable,
  output logic [DATA_W-1:0] pcm_mem_mm_readdata,
  output logic              pcm_mem_mm_readdatavalid,
`ifdef PCM_MEM_MM_PARITY_EN
  output logic              parity_err,
  output logic              parity_sticky,
`endif
  output logic              busy
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
`ifdef PCM_MEM_MM_PARITY_EN
  localparam int MEM_W  = DATA_W + BE_W;
  localparam int PIPE_W = DATA_W + 1;
`else
  localparam int MEM_W  = DATA_W;
  localparam int PIPE_W = DATA_W;
`endif

  logic [MEM_W-1:0]  mem_q [DEPTH];
  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [AW-1:0]     mem_addr, wr_idx;
  logic [MEM_W-1:0]  rd_word, wr_word;
  logic [DATA_W-1:0] merged, rd_data;
  logic [PIPE_W-1:0] pipe_in, pipe_out;
  logic              in_range, acc, wr_en, rd_issue, pipe_vld;

  assign in_range = 32'(pcm_mem_mm_address) < DEPTH;
  assign mem_addr = pcm_mem_mm_address[AW-1:0];
  assign rd_word  = mem_q[mem_addr];
  assign merged   = byte_merge(rd_word[DATA_W-1:0], pcm_mem_mm_writedata, pcm_mem_mm_byteenable);
  // An init in the same cycle wins over any access.
  assign acc      = (state_q == READY) && !init && pcm_mem_mm_chipselect && pcm_mem_mm_clken;
  assign rd_issue = acc && !pcm_mem_mm_write;
  assign rd_data  = in_range ? rd_word[DATA_W-1:0] : '0;
  assign busy     = (state_q == CLEAR);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    wr_idx  = mem_addr;
`ifdef PCM_MEM_MM_PARITY_EN
    wr_word = {byte_parity(merged), merged};
`else
    wr_word = merged;
`endif
    if (init) begin
      state_d = CLEAR;
      ptr_d   = '0;
    end else if (state_q == CLEAR) begin
      wr_en  = 1'b1;
      wr_idx = ptr_q;
`ifdef PCM_MEM_MM_PARITY_EN
      wr_word = {byte_parity(INIT_VALUE), INIT_VALUE};
`else
      wr_word = INIT_VALUE;
`endif
      if (ptr_q == LAST) begin
        state_d = READY;
        ptr_d   = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end else if (acc && pcm_mem_mm_write && in_range && (|pcm_mem_mm_byteenable)) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_word;
  end

`ifdef PCM_MEM_MM_PARITY_EN
  logic perr_in, sticky_q, sticky_d;
  assign perr_in = in_range && (byte_parity(rd_word[DATA_W-1:0]) != rd_word[MEM_W-1:DATA_W]);
  assign pipe_in = {perr_in, rd_data};
  assign parity_err    = pipe_vld && pipe_out[DATA_W];
  assign parity_sticky = sticky_q || parity_err;

  always_comb begin
    sticky_d = sticky_q || parity_err;
    if (init) sticky_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) sticky_q <= 1'b0;
    else       sticky_q <= sticky_d;
  end
`else
  assign pipe_in = rd_data;
`endif

  pcm_mem_mm_rd_pipe #(.LAT(READ_LATENCY), .W(PIPE_W)) u_rd_pipe (
    .clk      (clk),
    .reset    (reset),
    .clken    (pcm_mem_mm_clken),
    .flush    (init),
    .in_vld   (rd_issue),
    .in_data  (pipe_in),
    .out_vld  (pipe_vld),
    .out_data (pipe_out)
  );

  assign pcm_mem_mm_readdata      = pipe_out[DATA_W-1:0];
  assign pcm_mem_mm_readdatavalid = pipe_vld;
endmodule

// File: tb/tb_pcm_mem_mm_responder.sv
// Bench for pcm_mem_mm_responder: directed scenarios plus random traffic, all checked
// every cycle against a behavioural memory/response-queue model.
module tb_pcm_mem_mm_responder;
  localparam int DEPTH = 16;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        reset, init, cs, clken, wr;
  logic [10:0] addr;
  logic [15:0] wd, rdata;
  logic [1:0]  be;
  logic        rv, busy;
`ifdef PCM_MEM_MM_PARITY_EN
  logic        perr, psticky;
`endif

  always #5 clk = ~clk;

  pcm_mem_mm_responder #(.DEPTH(DEPTH), .READ_LATENCY(LAT), .INIT_VALUE(16'h0000)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .init                     (init),
    .pcm_mem_mm_address       (addr),
    .pcm_mem_mm_chipselect    (cs),
    .pcm_mem_mm_clken         (clken),
    .pcm_mem_mm_write         (wr),
    .pcm_mem_mm_writedata     (wd),
    .pcm_mem_mm_byteenable    (be),
    .pcm_mem_mm_readdata      (rdata),
    .pcm_mem_mm_readdatavalid (rv),
`ifdef PCM_MEM_MM_PARITY_EN
    .parity_err               (perr),
    .parity_sticky            (psticky),
`endif
    .busy                     (busy)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: word array, queue of pending responses tagged with the
  // enabled-cycle count at which they must appear, and a clear countdown.
  typedef struct { int due; logic [15:0] d; } rsp_t;
  logic [15:0] mm [DEPTH];
  rsp_t        q[$];
  int          en_cnt = 0;
  int          clear_left = DEPTH;
  logic        m_v = 1'b0;
  logic [15:0] m_d = 16'h0;

  always @(posedge clk) begin
    logic [3:0] a4;
    a4 = addr[3:0];
    if (reset || init) begin
      clear_left = DEPTH;
      q.delete();
      m_v = 1'b0;
      m_d = 16'h0;
      foreach (mm[i]) mm[i] = 16'h0;
    end else begin
      if (clear_left > 0) clear_left--;
      else if (cs && clken) begin
        if (wr) begin
          if (addr < DEPTH) begin
            if (be[0]) mm[a4][7:0]  = wd[7:0];
            if (be[1]) mm[a4][15:8] = wd[15:8];
          end
        end else begin
          q.push_back('{en_cnt + LAT, (addr < DEPTH) ? mm[a4] : 16'h0});
        end
      end
      if (clken) begin
        en_cnt++;
        if (q.size() > 0 && q[0].due == en_cnt) begin
          m_v = 1'b1;
          m_d = q[0].d;
          void'(q.pop_front());
        end else begin
          m_v = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rvalid", rv, m_v);
      chk("rdata", rdata, m_d);
      chk("busy", busy, clear_left > 0);
    end
  end

  task automatic idle();
    cs = 1'b0; wr = 1'b0; init = 1'b0; clken = 1'b1;
  endtask

  task automatic write_w(input logic [10:0] a, input logic [15:0] d, input logic [1:0] b);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; wd = d; be = b; clken = 1'b1;
    @(negedge clk);
    idle();
  endtask

  task automatic do_read(input logic [10:0] a, input logic [15:0] exp, input string nm);
    int lat;
    @(negedge clk);
    cs = 1'b1; wr = 1'b0; addr = a; clken = 1'b1;
    @(negedge clk);
    idle();
    lat = 1;
    while (!rv && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_valid"}, rv, 1'b1);
    chk({nm, "_lat"}, lat, LAT);
    chk(nm, rdata, exp);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", busy, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int          n;
    logic        ov [10];
    logic [15:0] od [10];
    reset = 1'b1; init = 1'b0; cs = 1'b0; clken = 1'b1; wr = 1'b0;
    addr = '0; wd = '0; be = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_rvalid", rv, 1'b0);
    chk("reset_rdata", rdata, 16'h0);
    chk("reset_busy", busy, 1'b1);

    // busy must stay high for exactly DEPTH cycles after reset drops
    reset = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("clear_cycles", n, DEPTH);

    for (int i = 0; i < DEPTH; i++) do_read(11'(i), 16'h0000, "clear_read");

    write_w(11'd5, 16'hA5C3, 2'b11);
    write_w(11'd5, 16'h1200, 2'b10);
    do_read(11'd5, 16'h12C3, "byte_merge");
    write_w(11'd5, 16'hFFFF, 2'b00);
    do_read(11'd5, 16'h12C3, "be_none");

    // back-to-back reads with a two-cycle clken stall after the second one
    write_w(11'd1, 16'h1111, 2'b11);
    write_w(11'd2, 16'h2222, 2'b11);
    write_w(11'd3, 16'h3333, 2'b11);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      ov[k] = rv;
      od[k] = rdata;
      idle();
      case (k)
        0: begin cs = 1'b1; addr = 11'd1; end
        1: begin cs = 1'b1; addr = 11'd2; end
        2, 3: clken = 1'b0;
        4: begin cs = 1'b1; addr = 11'd3; end
        default: ;
      endcase
    end
    chk("stall_hold_v3", ov[3], 1'b0);
    chk("stall_hold_v4", ov[4], 1'b0);
    chk("stall_hold_d4", od[4], 16'h12C3);
    chk("stall_v5", ov[5], 1'b1);
    chk("stall_d5", od[5], 16'h1111);
    chk("stall_v6", ov[6], 1'b1);
    chk("stall_d6", od[6], 16'h2222);
    chk("stall_v7", ov[7], 1'b1);
    chk("stall_d7", od[7], 16'h3333);
    chk("stall_v8", ov[8], 1'b0);

    // init wipes contents; a read while busy gets no response
    write_w(11'd7, 16'hBEEF, 2'b11);
    @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk("init_busy", busy, 1'b1);
    chk("init_rdata", rdata, 16'h0);
    cs = 1'b1; wr = 1'b0; addr = 11'd7;
    @(negedge clk);
    idle();
    n = 0;
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      if (rv) n++;
    end
    chk("busy_read_valids", n, 0);
    wait_ready();
    do_read(11'd7, 16'h0000, "after_init");

    // out-of-range accesses
    write_w(11'd20, 16'hFFFF, 2'b11);
    do_read(11'd20, 16'h0000, "oor_read");
    do_read(11'd4, 16'h0000, "no_alias");

`ifdef PCM_MEM_MM_PARITY_EN
    write_w(11'd3, 16'h1234, 2'b11);
    dut.mem_q[3][16] = ~dut.mem_q[3][16];
    do_read(11'd3, 16'h1234, "par_read");
    chk("par_err", perr, 1'b1);
    chk("par_sticky", psticky, 1'b1);
    @(negedge clk);
    chk("par_sticky_hold", psticky, 1'b1);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    chk("par_sticky_clr", psticky, 1'b0);
    wait_ready();
`endif

    // random traffic, including occasional init and clken stalls
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      init  = ($urandom_range(0, 199) == 0);
      cs    = ($urandom_range(0, 3) != 0);
      wr    = $urandom_range(0, 1) == 1;
      addr  = 11'($urandom_range(0, 23));
      wd    = 16'($urandom);
      be    = 2'($urandom_range(0, 3));
      clken = ($urandom_range(0, 4) != 0);
    end
    @(negedge clk);
    idle();
    repeat (DEPTH + LAT + 4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
